// File: rtl/ooo_issue_queue_if.sv
// Bundle of the issue-queue side signals: enqueue handshake from rename,
// writeback wakeup broadcasts, issue handshake to execute, flush and occupancy.
// The master modport is the surrounding pipeline; the slave modport is the queue.
interface ooo_issue_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IQ_SIZE    = 16,
    parameter int TAG_W      = 5,
    parameter int WB_PORTS   = 2
);
    localparam int CNT_W = $clog2(IQ_SIZE + 1);

    logic                      flush_i;

    logic                      enq_valid_i;
    logic                      enq_ready_o;
    logic [DATA_WIDTH-1:0]     enq_payload_i;
    logic [TAG_W-1:0]          enq_dst_tag_i;
    logic [TAG_W-1:0]          enq_src1_tag_i;
    logic [TAG_W-1:0]          enq_src2_tag_i;
    logic                      enq_src1_rdy_i;
    logic                      enq_src2_rdy_i;

    logic [WB_PORTS-1:0]       wb_valid_i;
    logic [WB_PORTS*TAG_W-1:0] wb_tag_i;

    logic                      iss_valid_o;
    logic                      iss_ready_i;
    logic [DATA_WIDTH-1:0]     iss_payload_o;
    logic [TAG_W-1:0]          iss_dst_tag_o;

    logic [CNT_W-1:0]          count_o;

    modport master (
        output flush_i,
        output enq_valid_i, enq_payload_i, enq_dst_tag_i,
        output enq_src1_tag_i, enq_src2_tag_i, enq_src1_rdy_i, enq_src2_rdy_i,
        input  enq_ready_o,
        output wb_valid_i, wb_tag_i,
        input  iss_valid_o, iss_payload_o, iss_dst_tag_o,
        output iss_ready_i,
        input  count_o
    );

    modport slave (
        input  flush_i,
        input  enq_valid_i, enq_payload_i, enq_dst_tag_i,
        input  enq_src1_tag_i, enq_src2_tag_i, enq_src1_rdy_i, enq_src2_rdy_i,
        output enq_ready_o,
        input  wb_valid_i, wb_tag_i,
        output iss_valid_o, iss_payload_o, iss_dst_tag_o,
        input  iss_ready_i,
        output count_o
    );
endinterface

// File: rtl/ooo_issue_queue.sv
// Out-of-order issue queue: compacting, age-ordered entry array (index 0 is
// oldest). Sources wake on writeback tag broadcasts; the oldest entry with
// both sources ready is presented for issue and removed on acceptance, with
// younger entries shifting down in the same edge.
// Optional feature macro: IQ_FAST_WAKEUP_EN -- lets a same-cycle broadcast
// make an entry eligible for issue (combinational wb_* -> iss_* path).
module ooo_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int IQ_SIZE    = 16,
    parameter int TAG_W      = 5,
    parameter int WB_PORTS   = 2
) (
    input logic             clk,
    input logic             rst,
    ooo_issue_queue_if.slave io
);
    localparam int CNT_W = $clog2(IQ_SIZE + 1);
    localparam int IDX_W = $clog2(IQ_SIZE);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] payload;
        logic [TAG_W-1:0]      dst_tag;
        logic [TAG_W-1:0]      s1_tag;
        logic                  s1_rdy;
        logic [TAG_W-1:0]      s2_tag;
        logic                  s2_rdy;
    } entry_t;

    entry_t              ent_q [IQ_SIZE];
    entry_t              ent_d [IQ_SIZE];
    logic [IQ_SIZE-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [IQ_SIZE-1:0]  s1_hit, s2_hit, elig;
    logic                enq_s1_hit, enq_s2_hit;
    logic [IDX_W-1:0]    sel_idx;
    logic                any_elig;
    logic                enq_fire, iss_fire;
    logic [CNT_W-1:0]    wr_idx;
    entry_t              enq_entry;

    // True when tag matches any valid writeback broadcast port (OR-reduced).
    function automatic logic tag_hit(
        input logic [TAG_W-1:0]          tag,
        input logic [WB_PORTS-1:0]       wb_valid,
        input logic [WB_PORTS*TAG_W-1:0] wb_tag
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Broadcast tag comparison for every stored source and for the incoming entry.
    always_comb begin
        for (int i = 0; i < IQ_SIZE; i++) begin
            s1_hit[i] = tag_hit(ent_q[i].s1_tag, io.wb_valid_i, io.wb_tag_i);
            s2_hit[i] = tag_hit(ent_q[i].s2_tag, io.wb_valid_i, io.wb_tag_i);
        end
        enq_s1_hit = tag_hit(io.enq_src1_tag_i, io.wb_valid_i, io.wb_tag_i);
        enq_s2_hit = tag_hit(io.enq_src2_tag_i, io.wb_valid_i, io.wb_tag_i);
    end

    // Eligibility per entry and oldest-first priority select.
    always_comb begin
        for (int i = 0; i < IQ_SIZE; i++) begin
`ifdef IQ_FAST_WAKEUP_EN
            elig[i] = valid_q[i] & (ent_q[i].s1_rdy | s1_hit[i])
                                 & (ent_q[i].s2_rdy | s2_hit[i]);
`else
            elig[i] = valid_q[i] & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
`endif
        end
        any_elig = |elig;
        sel_idx  = '0;
        // Scan downwards so the lowest eligible index wins.
        for (int i = IQ_SIZE - 1; i >= 0; i--) begin
            if (elig[i]) sel_idx = IDX_W'(i);
        end
    end

    assign io.iss_valid_o   = any_elig & ~io.flush_i;
    assign io.iss_payload_o = ent_q[sel_idx].payload;
    assign io.iss_dst_tag_o = ent_q[sel_idx].dst_tag;
    // No credit for a same-cycle issue: readiness depends on registered count only.
    assign io.enq_ready_o   = (count_q < CNT_W'(IQ_SIZE));
    assign io.count_o       = count_q;

    assign enq_fire = io.enq_valid_i & io.enq_ready_o & ~io.flush_i;
    assign iss_fire = io.iss_valid_o & io.iss_ready_i;

    // Next state: wakeup, then issue compaction, then enqueue write, flush last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ent_d   = ent_q;
        valid_d = valid_q;
        count_d = count_q + CNT_W'(enq_fire) - CNT_W'(iss_fire);
        wr_idx  = iss_fire ? (count_q - CNT_W'(1)) : count_q;

        enq_entry.payload = io.enq_payload_i;
        enq_entry.dst_tag = io.enq_dst_tag_i;
        enq_entry.s1_tag  = io.enq_src1_tag_i;
        enq_entry.s1_rdy  = io.enq_src1_rdy_i | enq_s1_hit;
        enq_entry.s2_tag  = io.enq_src2_tag_i;
        enq_entry.s2_rdy  = io.enq_src2_rdy_i | enq_s2_hit;

        for (int i = 0; i < IQ_SIZE; i++) begin
            if (s1_hit[i]) ent_d[i].s1_rdy = 1'b1;
            if (s2_hit[i]) ent_d[i].s2_rdy = 1'b1;
        end

        // Ascending order reads slot i+1 before it is itself overwritten,
        // so shifted entries carry their same-edge wakeups along.
        if (iss_fire) begin
            for (int i = 0; i < IQ_SIZE - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    ent_d[i]   = ent_d[i+1];
                    valid_d[i] = valid_d[i+1];
                end
            end
            valid_d[IQ_SIZE-1] = 1'b0;
        end

        for (int i = 0; i < IQ_SIZE; i++) begin
            if (enq_fire && (CNT_W'(i) == wr_idx)) begin
                ent_d[i]   = enq_entry;
                valid_d[i] = 1'b1;
            end
        end

        if (io.flush_i) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    // Control state: valid bits and occupancy, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Entry storage, qualified by valid_q.
    always_ff @(posedge clk) begin
        // NOTE: the entry array is deliberately not reset; stale contents are
        // masked by valid_q, and omitting reset keeps it a plain register file.
        ent_q <= ent_d;
    end
endmodule

// File: tb/tb_ooo_issue_queue.sv
// Directed self-checking bench for ooo_issue_queue (default 16 entries,
// 5-bit tags, 2 writeback ports). Expected values are hand-derived; steps
// whose timing depends on IQ_FAST_WAKEUP_EN are split on that macro.
module tb_ooo_issue_queue;
    localparam int DW = 32;
    localparam int N  = 16;
    localparam int TW = 5;
    localparam int WP = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ooo_issue_queue_if #(.DATA_WIDTH(DW), .IQ_SIZE(N), .TAG_W(TW), .WB_PORTS(WP)) io ();

    ooo_issue_queue #(.DATA_WIDTH(DW), .IQ_SIZE(N), .TAG_W(TW), .WB_PORTS(WP)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_enq(input logic v, input logic [TW-1:0] dst,
                             input logic [TW-1:0] s1, input logic r1,
                             input logic [TW-1:0] s2, input logic r2);
        io.enq_valid_i    = v;
        io.enq_dst_tag_i  = dst;
        io.enq_src1_tag_i = s1;
        io.enq_src1_rdy_i = r1;
        io.enq_src2_tag_i = s2;
        io.enq_src2_rdy_i = r2;
        io.enq_payload_i  = {24'hC0FFEE, 3'b000, dst};
    endtask

    task automatic drive_wb(input logic [WP-1:0] v, input logic [TW-1:0] t1, input logic [TW-1:0] t0);
        io.wb_valid_i = v;
        io.wb_tag_i   = {t1, t0};
    endtask

    task automatic idle();
        drive_enq(1'b0, '0, '0, 1'b1, '0, 1'b1);
        drive_wb('0, '0, '0);
        io.flush_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        io.iss_ready_i = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        settle();
        check("reset_count", io.count_o, 0);
        check("reset_iss_valid", io.iss_valid_o, 0);
        check("reset_enq_ready", io.enq_ready_o, 1);

        // Back-to-back ready entries issue in order, one cycle after enqueue
        drive_enq(1'b1, 5'd1, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("t1_empty_no_issue", io.iss_valid_o, 0);
        tick();
        drive_enq(1'b1, 5'd2, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("t1_iss_valid_1", io.iss_valid_o, 1);
        check("t1_iss_tag_1", io.iss_dst_tag_o, 1);
        check("t1_iss_payload_1", io.iss_payload_o, 32'hC0FFEE01);
        tick();
        drive_enq(1'b1, 5'd3, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("t1_count_enq_iss", io.count_o, 1);
        check("t1_iss_tag_2", io.iss_dst_tag_o, 2);
        tick();
        idle();
        settle();
        check("t1_iss_tag_3", io.iss_dst_tag_o, 3);
        check("t1_count_last", io.count_o, 1);
        tick();
        check("t1_count_drained", io.count_o, 0);
        check("t1_iss_valid_drained", io.iss_valid_o, 0);

        // Younger ready entry bypasses an older waiting one; wakeup on port 1
        drive_enq(1'b1, 5'd4, 5'd7, 1'b0, 5'd0, 1'b1);
        tick();
        drive_enq(1'b1, 5'd5, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("t2_a_not_ready", io.iss_valid_o, 0);
        tick();
        idle();
        settle();
        check("t2_b_first_valid", io.iss_valid_o, 1);
        check("t2_b_first_tag", io.iss_dst_tag_o, 5);
        tick();
        drive_wb(2'b10, 5'd7, 5'd0);
        settle();
`ifdef IQ_FAST_WAKEUP_EN
        check("t2_fast_wake_valid", io.iss_valid_o, 1);
        check("t2_fast_wake_tag", io.iss_dst_tag_o, 4);
        tick();
        idle();
        settle();
`else
        check("t2_wake_not_yet", io.iss_valid_o, 0);
        tick();
        idle();
        settle();
        check("t2_wake_valid", io.iss_valid_o, 1);
        check("t2_wake_tag", io.iss_dst_tag_o, 4);
        tick();
`endif
        check("t2_count_drained", io.count_o, 0);

        // Wakeup broadcast coinciding with enqueue is captured
        drive_enq(1'b1, 5'd6, 5'd0, 1'b1, 5'd9, 1'b0);
        drive_wb(2'b01, 5'd0, 5'd9);
        tick();
        idle();
        settle();
        check("t3_capture_valid", io.iss_valid_o, 1);
        check("t3_capture_tag", io.iss_dst_tag_o, 6);
        tick();
        check("t3_count_drained", io.count_o, 0);

        // Fill to capacity with waiting entries: src1 tag i, dst 16+i
        for (int i = 0; i < N; i++) begin
            drive_enq(1'b1, TW'(16 + i), TW'(i), 1'b0, 5'd0, 1'b1);
            tick();
        end
        drive_enq(1'b1, 5'd31, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("t4_full_count", io.count_o, 16);
        check("t4_full_enq_ready", io.enq_ready_o, 0);
        check("t4_full_no_issue", io.iss_valid_o, 0);
        drive_wb(2'b01, 5'd0, 5'd3);
        settle();
`ifdef IQ_FAST_WAKEUP_EN
        check("t4_fast_wake_valid", io.iss_valid_o, 1);
        check("t4_fast_wake_tag", io.iss_dst_tag_o, 19);
        tick();
        drive_wb('0, '0, '0);
        settle();
`else
        check("t4_wake_not_yet", io.iss_valid_o, 0);
        tick();
        drive_wb('0, '0, '0);
        settle();
        check("t4_wake_valid", io.iss_valid_o, 1);
        check("t4_wake_tag", io.iss_dst_tag_o, 19);
        check("t4_still_full", io.count_o, 16);
        check("t4_no_credit", io.enq_ready_o, 0);
        tick();
`endif
        check("t4_after_issue_count", io.count_o, 15);
        check("t4_after_issue_ready", io.enq_ready_o, 1);
        check("t4_after_issue_idle", io.iss_valid_o, 0);
        tick();
        drive_enq(1'b0, '0, '0, 1'b1, '0, 1'b1);
        settle();
        check("t4_refill_count", io.count_o, 16);
        check("t4_refill_tag", io.iss_dst_tag_o, 31);
        tick();
        check("t4_issue31_count", io.count_o, 15);
        // Wake shifted entries dst 18 (src1 2) and dst 20 (src1 4) together
        drive_wb(2'b11, 5'd4, 5'd2);
        settle();
`ifdef IQ_FAST_WAKEUP_EN
        check("t4_fast_oldest_tag", io.iss_dst_tag_o, 18);
        tick();
        drive_wb('0, '0, '0);
        settle();
`else
        check("t4_pair_not_yet", io.iss_valid_o, 0);
        tick();
        drive_wb('0, '0, '0);
        settle();
        check("t4_oldest_tag", io.iss_dst_tag_o, 18);
        tick();
`endif
        check("t4_next_tag", io.iss_dst_tag_o, 20);
        tick();
        check("t4_pair_count", io.count_o, 13);
        io.flush_i = 1'b1;
        settle();
        check("t4_flush_blocks_issue", io.iss_valid_o, 0);
        tick();
        io.flush_i = 1'b0;
        settle();
        check("t4_flush_count", io.count_o, 0);

        // Flush beats simultaneous enqueue and pending issue
        io.iss_ready_i = 1'b0;
        drive_enq(1'b1, 5'd1, 5'd0, 1'b1, 5'd0, 1'b1);
        tick();
        for (int i = 2; i <= 5; i++) begin
            drive_enq(1'b1, TW'(i), 5'd30, 1'b0, 5'd0, 1'b1);
            tick();
        end
        drive_enq(1'b0, '0, '0, 1'b1, '0, 1'b1);
        settle();
        check("t5_count5", io.count_o, 5);
        check("t5_pending_tag", io.iss_dst_tag_o, 1);
        io.iss_ready_i = 1'b1;
        io.flush_i = 1'b1;
        drive_enq(1'b1, 5'd7, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("t5_flush_iss_valid", io.iss_valid_o, 0);
        tick();
        idle();
        settle();
        check("t5_flush_count", io.count_o, 0);
        check("t5_flush_no_enq", io.iss_valid_o, 0);

        // Reset mid-operation drops all entries
        io.iss_ready_i = 1'b0;
        for (int i = 8; i < 12; i++) begin
            drive_enq(1'b1, TW'(i), 5'd0, 1'b1, 5'd0, 1'b1);
            tick();
        end
        settle();
        check("t6_count4", io.count_o, 4);
        check("t6_iss_tag", io.iss_dst_tag_o, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        settle();
        check("t6_rst_count", io.count_o, 0);
        check("t6_rst_iss_valid", io.iss_valid_o, 0);
        check("t6_rst_enq_ready", io.enq_ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ooo_issue_queue.md
# ooo_issue_queue

Parametrised out-of-order issue queue sitting between decode/rename and the execute units. It holds renamed instructions until their source operands are ready and snoops `WB_PORTS` writeback tag broadcasts to wake waiting sources. Each cycle it issues the oldest ready entry. Storage is a compacting, age-ordered array with a valid/ready handshake on both sides, plus a pipeline flush.

## Interface
Parameters:
- `DATA_WIDTH`, 32: opaque payload width (decoded instruction bundle).
- `IQ_SIZE`, 16: number of entries; must be ≥2.
- `TAG_W`, 5: ROB tag width; supports a 32-entry ROB.
- `WB_PORTS`, 2: number of writeback wakeup broadcast ports.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `flush_i`, input, 1: discard all entries (mispredict/exception).
- `enq_valid_i`, input, 1: enqueue request.
- `enq_ready_o`, output, 1: queue can accept an entry.
- `enq_payload_i`, input, `DATA_WIDTH`: instruction payload.
- `enq_dst_tag_i`, input, `TAG_W`: destination ROB tag.
- `enq_src1_tag_i` / `enq_src2_tag_i`, input, `TAG_W` each: source producer tags.
- `enq_src1_rdy_i` / `enq_src2_rdy_i`, input, 1 each: source already available (ARF or completed ROB).
- `wb_valid_i`, input, `WB_PORTS`: broadcast valid per port.
- `wb_tag_i`, input, `WB_PORTS*TAG_W`: broadcast tags; port p occupies bits `[p*TAG_W +: TAG_W]`.
- `iss_valid_o`, output, 1: an entry is presented for issue.
- `iss_ready_i`, input, 1: execute side accepts.
- `iss_payload_o`, output, `DATA_WIDTH`: issued payload.
- `iss_dst_tag_o`, output, `TAG_W`: issued destination tag.
- `count_o`, output, `$clog2(IQ_SIZE+1)`: occupied entries.

## Operation
- Entry fields: `valid`, `payload`, `dst_tag`, `s1_tag`, `s1_rdy`, `s2_tag`, `s2_rdy`. Entries `0..count-1` are valid. Index 0 holds the oldest entry.
- Enqueue fires when `enq_valid_i & enq_ready_o & !flush_i`.
  - `enq_ready_o = (count_o < IQ_SIZE)`. No credit is taken for a same-cycle issue, so a full queue refuses enqueue even while issuing.
- Enqueue capture:
  - Stored `sN_rdy = enq_srcN_rdy_i | (enq_srcN_tag_i` matches any valid `wb_tag_i` this cycle`)`.
  - This capture is always built, regardless of configuration.
- Wakeup:
  - For every valid entry and each source, `sN_rdy` is set at the clock edge when `sN_tag` equals any `wb_tag_i[p]` with `wb_valid_i[p]`.
  - `sN_rdy` is never cleared except by dequeue, flush or reset.
- Select:
  - An entry is eligible when valid and both sources are ready (see Configuration).
  - `iss_valid_o = any eligible & !flush_i`.
  - The payload and tag come from the lowest-index eligible entry (oldest-first), via a combinational priority mux.
- Issue fires when `iss_valid_o & iss_ready_i`.
  - The selected entry is removed, and entries above it shift down one index in the same edge, preserving age order.
  - An accepted new entry is written at index `count-1` when issuing and at index `count` otherwise.
  - `count_o` is unchanged on a simultaneous enqueue and issue.
- Flush: at the next edge all `valid` bits clear and `count_o` becomes 0. Flush has priority over enqueue, issue and wakeup. Payload contents need not be cleared.
- Reset: all `valid` bits 0 and `count_o` 0, so `iss_valid_o` is 0 and `enq_ready_o` is 1. Reset overrides flush and all other inputs. Reset asserted mid-operation drops every entry.
- A tag equal on two wakeup ports is harmless (OR-reduced).

## Timing
- Enqueue to earliest issue is 1 cycle: the entry is visible the cycle after acceptance if its sources are ready.
- Writeback broadcast to issue of a dependent entry:
  - 1 cycle by default (ready bit registered).
  - 0 cycles with `IQ_FAST_WAKEUP_EN`.
- `iss_*` outputs are combinational from state (and from `wb_*` under fast wakeup). `enq_ready_o` and `count_o` are pure functions of registered state.
- `iss_payload_o` and `iss_dst_tag_o` are don't-care while `iss_valid_o` = 0. They must hold stable while `iss_valid_o & !iss_ready_i`, unless an older entry becomes eligible.

## Configuration
- `IQ_FAST_WAKEUP_EN` defined:
  - Select eligibility uses `sN_rdy | match(sN_tag, wb_*)`, so a dependent entry can issue in the same cycle as its producer's broadcast.
  - Adds a combinational path from `wb_*` to `iss_*`.
- Undefined: eligibility uses registered `sN_rdy` only. Wakeup-to-issue is 1 cycle and there is no `wb_*` → `iss_*` path.

## Test plan
- Reset, then enqueue 3 entries with both sources ready (dst tags 1, 2, 3), `iss_ready_i` = 1 → issues tags 1, 2, 3 in consecutive cycles starting the cycle after the first enqueue; `count_o` returns to 0.
- Enqueue entry A (src1 tag 7, not ready) then entry B (both ready) → B issues first. Broadcast tag 7 on port 1 → A issues 1 cycle later (0 cycles with `IQ_FAST_WAKEUP_EN`).
- Enqueue with src2 tag 9 not ready in the same cycle `wb_tag` = 9 is broadcast → entry issues the next cycle; no lost wakeup.
- Fill `IQ_SIZE` entries with sources not ready → `enq_ready_o` = 0 and `count_o` = 16. Hold `enq_valid_i` with `iss_ready_i` = 1 while waking one entry → issue and enqueue do not overlap (no credit), and `count_o` stays ≤16.
- With 5 valid entries, assert `flush_i` together with `enq_valid_i` and a pending issue → `iss_valid_o` = 0 that cycle; the next cycle `count_o` = 0 and nothing was enqueued.
- Assert `rst` with 4 entries present → the next cycle `count_o` = 0, `iss_valid_o` = 0, `enq_ready_o` = 1.
